// File: rtl/mem_access.sv
// mem_access: RV32I memory stage turning load/store ops into req/ack bus transactions
module mem_access #(
   parameter int          TIMEOUT    = 64,
   parameter logic [31:0] RESET_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic        stall_in,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] result_in,
   input  logic [31:0] rs2_value_in,
   input  logic [4:0]  rd_in,
   output logic        stall_out,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        valid_out,
   output logic        rd_write,
   output logic [4:0]  rd_out,
   output logic [31:0] result_out,
   output logic        misalign_out,
   output logic        bus_err_out
);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0] f3_q;
   logic [1:0] a_q;
   logic [31:0] hold_q, sh_data, load_val, wdata_nx;
   logic [3:0] be_nx;
   logic err_q, is_ld, is_st, is_mem, take, mis, tmo, emit;
   logic [7:0] lane_b;
   logic [15:0] lane_h;
   assign is_ld = opcode_in == 7'b0000011;
   assign is_st = opcode_in == 7'b0100011;
   assign is_mem = is_ld || is_st;
   assign take = state == IDLE && valid_in && !stall_in;
   assign mis = funct3_in[1] ? |result_in[1:0] : funct3_in[0] & result_in[0];
   assign be_nx = funct3_in[1] ? 4'b1111 : funct3_in[0] ? 4'b0011 << result_in[1:0] : 4'b0001 << result_in[1:0];
   assign wdata_nx = funct3_in[1] ? rs2_value_in : funct3_in[0] ? {2{rs2_value_in[15:0]}} : {4{rs2_value_in[7:0]}};
   assign tmo = state == BUS && !dbus_ack && cnt == CNT_MAX;
   assign emit = state == DONE && !stall_in;
   assign sh_data = dbus_rdata >> {a_q, 3'b000};
   assign lane_b = sh_data[7:0];
   assign lane_h = sh_data[15:0];
   assign load_val = f3_q[1] ? dbus_rdata
                   : f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h}
                   : {{24{~f3_q[2] & lane_b[7]}}, lane_b};
   assign stall_out = state != IDLE;
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   // next-state: IDLE -> BUS on an aligned mem op, BUS -> DONE on ack or timeout, DONE -> IDLE when writeback ready
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (take && is_mem && !mis) ? BUS : IDLE;
         BUS:     state_nx = (dbus_ack || tmo) ? DONE : BUS;
         DONE:    state_nx = stall_in ? DONE : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // bus outputs, captured access info, timeout counter and writeback-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbus_req     <= 1'b0;
         dbus_we      <= 1'b0;
         dbus_addr    <= RESET_ADDR;
         dbus_wdata   <= '0;
         dbus_be      <= '0;
         valid_out    <= 1'b0;
         rd_write     <= 1'b0;
         rd_out       <= '0;
         result_out   <= '0;
         misalign_out <= 1'b0;
         bus_err_out  <= 1'b0;
         cnt          <= '0;
         f3_q         <= '0;
         a_q          <= '0;
         hold_q       <= '0;
         err_q        <= 1'b0;
      end else begin
         valid_out    <= 1'b0;
         misalign_out <= 1'b0;
         bus_err_out  <= 1'b0;
         if (take) begin
            rd_out <= rd_in;
            if (!is_mem) begin
               valid_out  <= 1'b1;
               result_out <= result_in;
               rd_write   <= rd_in != 5'd0 && opcode_in != 7'b1100011;
            end else if (mis) begin
               valid_out    <= 1'b1;
               misalign_out <= 1'b1;
               result_out   <= result_in;
               rd_write     <= 1'b0;
            end else begin
               dbus_req   <= 1'b1;
               dbus_we    <= is_st;
               dbus_addr  <= {result_in[31:2], 2'b00};
               dbus_be    <= be_nx;
               dbus_wdata <= wdata_nx;
               f3_q       <= funct3_in;
               a_q        <= result_in[1:0];
               cnt        <= '0;
               err_q      <= 1'b0;
               rd_write   <= 1'b0;
            end
         end
         if (state == BUS) begin
            if (dbus_ack) begin
               dbus_req <= 1'b0;
               hold_q   <= load_val;
            end else if (tmo) begin
               dbus_req <= 1'b0;
               hold_q   <= '0;
               err_q    <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (emit) begin
            valid_out   <= 1'b1;
            bus_err_out <= err_q;
            result_out  <= hold_q;
            rd_write    <= !dbus_we && !err_q && rd_out != 5'd0;
         end
      end
   end
endmodule
